// File: rtl/vtim_pkg.sv
// vtim_pkg: shared 640x480 raster constants (active, totals, sync bounds for vsig) and the vtim flag record
package vtim_pkg;
  localparam int DEF_XWIDTH = 10;
  localparam int DEF_YWIDTH = 10;
  localparam int H_ACT = 640;
  localparam int H_TOT = 800;
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END = 752;
  localparam int V_ACT = 480;
  localparam int V_TOT = 525;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END = 492;
  localparam int DEF_PREFETCH = 32;
  typedef struct packed {
    logic act_h;
    logic act_v;
    logic frame_start;
    logic line_end;
    logic fetch_req;
  } vtim_flags_t;
  localparam vtim_flags_t FLAGS_RST = '{act_h: 1'b1, act_v: 1'b1, default: 1'b0};
endpackage

// File: rtl/vtim_if.sv
// vtim_if: timing bundle; master (vtim) takes Run and drives counters, active flags, strobes, FetchLine; slave is the consumer side
interface vtim_if #(
  parameter int XWIDTH = vtim_pkg::DEF_XWIDTH,
  parameter int YWIDTH = vtim_pkg::DEF_YWIDTH
);
  logic Run;
  logic [XWIDTH-1:0] PixelCnt;
  logic [YWIDTH-1:0] LineCnt;
  logic [YWIDTH-1:0] FetchLine;
  logic IsActHorz;
  logic IsActVert;
  logic FrameStart;
  logic LineEnd;
  logic FetchReq;
  modport master (
    input Run,
    output PixelCnt, LineCnt, IsActHorz, IsActVert, FrameStart, LineEnd, FetchReq, FetchLine
  );
  modport slave (
    output Run,
    input PixelCnt, LineCnt, IsActHorz, IsActVert, FrameStart, LineEnd, FetchReq, FetchLine
  );
endinterface

// File: rtl/vtim_cnt.sv
// vtim_cnt: wrap counter 0..N-1; ports PixelClk, nReset (sync active-low), en, q (count), nxt (value after this edge), tc (q==N-1)
module vtim_cnt #(
  parameter int W = 10,
  parameter int N = 800
) (
  input  logic         PixelClk,
  input  logic         nReset,
  input  logic         en,
  output logic [W-1:0] q,
  output logic [W-1:0] nxt,
  output logic         tc
);
  localparam logic [W-1:0] LAST = W'(N - 1);
  assign tc = q == LAST;
  assign nxt = !en ? q : tc ? '0 : q + W'(1);
  always_ff @(posedge PixelClk)
    if (!nReset) q <= '0;
    else q <= nxt;
endmodule

// File: rtl/vtim.sv
// vtim: video timing generator; ports PixelClk, nReset (sync active-low), t (vtim_if.master: Run in; PixelCnt, LineCnt, IsActHorz/Vert, FrameStart, LineEnd, FetchReq, FetchLine out)
module vtim import vtim_pkg::*; #(
  parameter int XWIDTH = DEF_XWIDTH,
  parameter int YWIDTH = DEF_YWIDTH,
  parameter int HACT = H_ACT,
  parameter int HTOT = H_TOT,
  parameter int VACT = V_ACT,
  parameter int VTOT = V_TOT,
  parameter int PREFETCH = DEF_PREFETCH
) (
  input logic    PixelClk,
  input logic    nReset,
  vtim_if.master t
);
  if (!(HACT < HTOT && VACT < VTOT && PREFETCH >= 1 && PREFETCH <= HTOT - HACT &&
        HTOT <= 2 ** XWIDTH && VTOT <= 2 ** YWIDTH)) begin : g_bad_params
    $fatal(1, "vtim: illegal timing parameters");
  end
  localparam logic [XWIDTH-1:0] H_ACT_C = XWIDTH'(HACT);
  localparam logic [XWIDTH-1:0] H_LAST = XWIDTH'(HTOT - 1);
  localparam logic [XWIDTH-1:0] H_PF = XWIDTH'(HTOT - PREFETCH);
  localparam logic [YWIDTH-1:0] V_ACT_C = YWIDTH'(VACT);
  localparam logic [YWIDTH-1:0] V_LAST = YWIDTH'(VTOT - 1);
  logic [XWIDTH-1:0] h_q, h_nxt;
  logic [YWIDTH-1:0] v_q, v_nxt, fl_nxt, fetch_line;
  logic h_tc, v_tc;
  vtim_flags_t f, f_nxt;
  vtim_cnt #(.W(XWIDTH), .N(HTOT)) u_h (
    .PixelClk(PixelClk), .nReset(nReset), .en(t.Run),
    .q(h_q), .nxt(h_nxt), .tc(h_tc)
  );
  vtim_cnt #(.W(YWIDTH), .N(VTOT)) u_v (
    .PixelClk(PixelClk), .nReset(nReset), .en(t.Run && h_tc),
    .q(v_q), .nxt(v_nxt), .tc(v_tc)
  );
  // Flags are computed from the counters' next values so they land in the same cycle as the counts they describe.
  assign fl_nxt = v_nxt == V_LAST ? '0 : v_nxt + YWIDTH'(1);
  always_comb
    f_nxt = '{
      act_h:       h_nxt < H_ACT_C,
      act_v:       v_nxt < V_ACT_C,
      frame_start: t.Run && h_tc && v_tc,
      line_end:    t.Run && h_nxt == H_LAST,
      fetch_req:   t.Run && h_nxt == H_PF && fl_nxt < V_ACT_C
    };
  always_ff @(posedge PixelClk)
    if (!nReset) begin
      f <= FLAGS_RST;
      fetch_line <= '0;
    end else begin
      f <= f_nxt;
      fetch_line <= fl_nxt;
    end
  assign t.PixelCnt = h_q;
  assign t.LineCnt = v_q;
  assign t.IsActHorz = f.act_h;
  assign t.IsActVert = f.act_v;
  assign t.FrameStart = f.frame_start;
  assign t.LineEnd = f.line_end;
  assign t.FetchReq = f.fetch_req;
  assign t.FetchLine = fetch_line;
endmodule
